uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Purpose: parameterised UART receiver (data bits, parity mode, stop bits) with a 2-flop rx synchronizer.
// Latency: rx_valid appears 4 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT clk cycles after the rx falling edge.
// Backpressure: none; rx_valid is a one-cycle pulse, and rx_data holds its value until the next completed frame.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam int             BW        = 4;
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF      = CW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE,
        ST_WAIT_HIGH
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_acc_q, perr_acc_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   rx_s;

    // Synchronizer: shift the raw line through two flops; sync_q[1] is the only copy the FSM sees.
    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    assign rx_s = sync_q[1];

    // Next-state and datapath: every sample is taken on the edge that leaves a bit period.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                bit_d      = '0;
                perr_acc_d = 1'b0;
                ferr_acc_d = 1'b0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Re-check the start bit near its middle; a high line here was only a glitch.
                if (cnt_q == HALF) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    // Odd mode wants the XOR of data and parity bit to be 1, even mode wants 0.
                    if (PARITY == 1) begin
                        perr_acc_d = ~(^shift_q ^ rx_s);
                    end else begin
                        perr_acc_d = ^shift_q ^ rx_s;
                    end
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_acc_d = 1'b1;
                    end
                    if (bit_q == STOP_LAST) begin
                        bit_d        = '0;
                        state_d      = ST_DONE;
                        rx_valid_d   = 1'b1;
                        rx_data_d    = shift_q;
                        parity_err_d = perr_acc_d;
                        frame_err_d  = ferr_acc_d;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_DONE: begin
                // A framing error usually means a break; wait for the line to recover before rearming.
                state_d = frame_err_q ? ST_WAIT_HIGH : ST_IDLE;
            end
            ST_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The bit-period counter restarts on every state change.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sync_q       <= 2'b11;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_WAIT_HIGH);

endmodule
